// File: rtl/aes_if.sv
// Request/result bundle of the AES-128 core: key load plus the encrypt and decrypt channels.
interface aes_if;
    logic [127:0] io_key;
    logic         io_startKeyExp;
    logic         io_keyExpReady;
    logic         io_encIntf_text_valid;
    logic [127:0] io_encIntf_text_bits_0;
    logic         io_encIntf_cipher_valid;
    logic [127:0] io_encIntf_cipher_bits_0;
    logic         io_decIntf_cipher_valid;
    logic [127:0] io_decIntf_cipher_bits_0;
    logic         io_decIntf_text_valid;
    logic [127:0] io_decIntf_text_bits_0;
    logic         io_encEngReady;
    logic         io_decEngReady;

    modport master (
        output io_key, io_startKeyExp,
        output io_encIntf_text_valid, io_encIntf_text_bits_0,
        output io_decIntf_cipher_valid, io_decIntf_cipher_bits_0,
        input  io_keyExpReady, io_encEngReady, io_decEngReady,
        input  io_encIntf_cipher_valid, io_encIntf_cipher_bits_0,
        input  io_decIntf_text_valid, io_decIntf_text_bits_0
    );

    modport slave (
        input  io_key, io_startKeyExp,
        input  io_encIntf_text_valid, io_encIntf_text_bits_0,
        input  io_decIntf_cipher_valid, io_decIntf_cipher_bits_0,
        output io_keyExpReady, io_encEngReady, io_decEngReady,
        output io_encIntf_cipher_valid, io_encIntf_cipher_bits_0,
        output io_decIntf_text_valid, io_decIntf_text_bits_0
    );
endinterface

// File: rtl/aes_top.sv
// Iterative AES-128 core: stored key schedule, independent one-round-per-cycle encrypt and decrypt engines.
module aes_top (
    input logic  clock,
    input logic  reset,
    aes_if.slave bus
);
    localparam logic [2047:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [2047:0] INV_SBOX = {
        256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d};
    // Entry 0 is a spacer so the round counter indexes its own constant.
    localparam logic [87:0] RCON = 88'h00_01020408102040801b36;

    typedef enum logic {IDLE, EXPAND} keyState_t;

    keyState_t    keyState;
    logic [3:0]   keyCount;
    logic         keyReady;
    logic [127:0] roundKey [0:10];
    logic         encBusy, decBusy, encValid, decValid;
    logic [3:0]   encRound, decRound;
    logic [127:0] encState, decState, encBits, decBits;
    logic [127:0] encNext, decNext, keyNext;

    function automatic logic [7:0] sub(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] invSub(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Byte (row r, column c) lives at bits 127-32c-8r, so a column is one contiguous 32-bit word.
    function automatic logic [127:0] mixColumns(input logic [127:0] s, input logic inverse);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            if (inverse)
                o[127-32*c -: 32] = {gmul(a0,4'd14)^gmul(a1,4'd11)^gmul(a2,4'd13)^gmul(a3,4'd9),
                                     gmul(a0,4'd9)^gmul(a1,4'd14)^gmul(a2,4'd11)^gmul(a3,4'd13),
                                     gmul(a0,4'd13)^gmul(a1,4'd9)^gmul(a2,4'd14)^gmul(a3,4'd11),
                                     gmul(a0,4'd11)^gmul(a1,4'd13)^gmul(a2,4'd9)^gmul(a3,4'd14)};
            else
                o[127-32*c -: 32] = {gmul(a0,4'd2)^gmul(a1,4'd3)^a2^a3,
                                     a0^gmul(a1,4'd2)^gmul(a2,4'd3)^a3,
                                     a0^a1^gmul(a2,4'd2)^gmul(a3,4'd3),
                                     gmul(a0,4'd3)^a1^a2^gmul(a3,4'd2)};
        end
        return o;
    endfunction

    function automatic logic [127:0] encStep(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-32*c-8*r -: 8] = sub(s[127-32*((c+r)%4)-8*r -: 8]);
        if (!last) t = mixColumns(t, 1'b0);
        return t ^ k;
    endfunction

    function automatic logic [127:0] decStep(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-32*c-8*r -: 8] = invSub(s[127-32*((c+4-r)%4)-8*r -: 8]);
        t = t ^ k;
        if (!last) t = mixColumns(t, 1'b1);
        return t;
    endfunction

    function automatic logic [127:0] expandStep(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sub(k[23:16]) ^ rc, sub(k[15:8]), sub(k[7:0]), sub(k[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_comb begin
        encNext = encStep(encState, roundKey[encRound], encRound == 4'd10);
        decNext = decStep(decState, roundKey[4'd10 - decRound], decRound == 4'd10);
        keyNext = expandStep(roundKey[keyCount - 4'd1], RCON[87 - 8*int'(keyCount) -: 8]);
    end

    // Key expansion may only restart while both engines are idle, so a running operation never sees keys change.
    always_ff @(posedge clock) begin
        if (!reset) begin
            keyState <= IDLE;
            keyCount <= 4'd0;
            keyReady <= 1'b0;
            for (int i = 0; i < 11; i++) roundKey[i] <= '0;
        end else begin
            case (keyState)
                IDLE: begin
                    if (bus.io_startKeyExp && !encBusy && !decBusy) begin
                        roundKey[0] <= bus.io_key;
                        keyCount    <= 4'd1;
                        keyReady    <= 1'b0;
                        keyState    <= EXPAND;
                    end
                end
                EXPAND: begin
                    roundKey[keyCount] <= keyNext;
                    if (keyCount == 4'd10) begin
                        keyCount <= 4'd0;
                        keyReady <= 1'b1;
                        keyState <= IDLE;
                    end else begin
                        keyCount <= keyCount + 4'd1;
                    end
                end
                default: keyState <= IDLE;
            endcase
        end
    end

    // Encrypt engine: whitening on accept, then rounds 1..10 with the result latched on round 10.
    always_ff @(posedge clock) begin
        if (!reset) begin
            encBusy  <= 1'b0;
            encRound <= 4'd0;
            encState <= '0;
            encValid <= 1'b0;
            encBits  <= '0;
        end else begin
            encValid <= 1'b0;
            if (encBusy) begin
                encState <= encNext;
                if (encRound == 4'd10) begin
                    encBusy  <= 1'b0;
                    encValid <= 1'b1;
                    encBits  <= encNext;
                    encRound <= 4'd0;
                end else begin
                    encRound <= encRound + 4'd1;
                end
            end else if (bus.io_encIntf_text_valid && keyReady) begin
                encState <= bus.io_encIntf_text_bits_0 ^ roundKey[0];
                encRound <= 4'd1;
                encBusy  <= 1'b1;
            end
        end
    end

    // Decrypt engine walks the schedule backwards, starting from the last round key.
    always_ff @(posedge clock) begin
        if (!reset) begin
            decBusy  <= 1'b0;
            decRound <= 4'd0;
            decState <= '0;
            decValid <= 1'b0;
            decBits  <= '0;
        end else begin
            decValid <= 1'b0;
            if (decBusy) begin
                decState <= decNext;
                if (decRound == 4'd10) begin
                    decBusy  <= 1'b0;
                    decValid <= 1'b1;
                    decBits  <= decNext;
                    decRound <= 4'd0;
                end else begin
                    decRound <= decRound + 4'd1;
                end
            end else if (bus.io_decIntf_cipher_valid && keyReady) begin
                decState <= bus.io_decIntf_cipher_bits_0 ^ roundKey[10];
                decRound <= 4'd1;
                decBusy  <= 1'b1;
            end
        end
    end

    assign bus.io_keyExpReady           = keyReady;
    assign bus.io_encEngReady           = keyReady && !encBusy;
    assign bus.io_decEngReady           = keyReady && !decBusy;
    assign bus.io_encIntf_cipher_valid  = encValid;
    assign bus.io_encIntf_cipher_bits_0 = encBits;
    assign bus.io_decIntf_text_valid    = decValid;
    assign bus.io_decIntf_text_bits_0   = decBits;
endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: FIPS-197 vectors plus random traffic against a table-free AES model.
module tb_aes_top;
    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] sboxT [256];
    logic [7:0] invT  [256];

    aes_if bus();
    aes_top dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-boxes derived from first principles: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic buildTables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sboxT[x] = s;
            invT[s]  = 8'(x);
        end
    endtask

    function automatic logic [127:0] roundKeyOf(input logic [127:0] key, input int round);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sboxT[t[23:16]] ^ rc, sboxT[t[15:8]], sboxT[t[7:0]], sboxT[t[31:24]]};
                rc = gfMul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*round], w[4*round+1], w[4*round+2], w[4*round+3]};
    endfunction

    function automatic logic [127:0] modelEncrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        logic [7:0]   coef [4];
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        v = pt ^ roundKeyOf(key, 0);
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
            for (int i = 0; i < 16; i++) t[i] = sboxT[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int i = 0; i < 16; i++) begin
                if (rnd == 10) s[i] = t[i];
                else begin
                    s[i] = 8'h00;
                    for (int k = 0; k < 4; k++)
                        s[i] = s[i] ^ gfMul(t[k + 4*(i/4)], coef[(k - (i%4) + 4) % 4]);
                end
            end
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
            v = v ^ roundKeyOf(key, rnd);
        end
        return v;
    endfunction

    function automatic logic [127:0] modelDecrypt(input logic [127:0] key, input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        logic [7:0]   coef [4];
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        v = ct ^ roundKeyOf(key, 10);
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
            for (int i = 0; i < 16; i++) t[i] = invT[s[(i%4) + 4*(((i/4) + 4 - (i%4)) % 4)]];
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
            v = v ^ roundKeyOf(key, rnd);
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) t[i] = v[127-8*i -: 8];
                for (int i = 0; i < 16; i++) begin
                    s[i] = 8'h00;
                    for (int k = 0; k < 4; k++)
                        s[i] = s[i] ^ gfMul(t[k + 4*(i/4)], coef[(k - (i%4) + 4) % 4]);
                end
                for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
            end
        end
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic loadKey(input logic [127:0] key, output int edges);
        bus.io_key = key;
        bus.io_startKeyExp = 1'b1;
        tick();
        bus.io_startKeyExp = 1'b0;
        edges = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (bus.io_keyExpReady && edges < 0) edges = n;
        end
    endtask

    // One accept edge, then a bounded observation window; optional start or reset pulse before edge startAt/resetAt.
    task automatic applyStimulus(input bit doEnc, input bit doDec, input logic [127:0] pt, input logic [127:0] ct,
                                 input int startAt, input int resetAt,
                                 output int encEdge, output int decEdge, output int encPulses, output int decPulses,
                                 output logic [127:0] encOut, output logic [127:0] decOut, output bit keyDropped);
        bus.io_encIntf_text_valid    = doEnc;
        bus.io_encIntf_text_bits_0   = pt;
        bus.io_decIntf_cipher_valid  = doDec;
        bus.io_decIntf_cipher_bits_0 = ct;
        tick();
        bus.io_encIntf_text_valid    = 1'b0;
        bus.io_decIntf_cipher_valid  = 1'b0;
        bus.io_encIntf_text_bits_0   = rand128();
        bus.io_decIntf_cipher_bits_0 = rand128();
        encEdge = -1; decEdge = -1; encPulses = 0; decPulses = 0;
        encOut = '0; decOut = '0; keyDropped = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            if (n == startAt) bus.io_startKeyExp = 1'b1;
            if (n == resetAt) reset = 1'b0;
            tick();
            bus.io_startKeyExp = 1'b0;
            reset = 1'b1;
            if (!bus.io_keyExpReady) keyDropped = 1'b1;
            if (bus.io_encIntf_cipher_valid) begin
                encPulses++;
                if (encEdge < 0) begin encEdge = n; encOut = bus.io_encIntf_cipher_bits_0; end
            end
            if (bus.io_decIntf_text_valid) begin
                decPulses++;
                if (decEdge < 0) begin decEdge = n; decOut = bus.io_decIntf_text_bits_0; end
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".keyExpReady"}, 128'(bus.io_keyExpReady), 128'd0);
        checkOutput({tag, ".encEngReady"}, 128'(bus.io_encEngReady), 128'd0);
        checkOutput({tag, ".decEngReady"}, 128'(bus.io_decEngReady), 128'd0);
        checkOutput({tag, ".cipherValid"}, 128'(bus.io_encIntf_cipher_valid), 128'd0);
        checkOutput({tag, ".textValid"}, 128'(bus.io_decIntf_text_valid), 128'd0);
        checkOutput({tag, ".cipherBits"}, bus.io_encIntf_cipher_bits_0, 128'd0);
        checkOutput({tag, ".textBits"}, bus.io_decIntf_text_bits_0, 128'd0);
    endtask

    initial begin
        int           encEdge, decEdge, encPulses, decPulses, edges, first, second;
        logic [127:0] encOut, decOut, key, pt, ct;
        bit           keyDropped;
        localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
        localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
        localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
        localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

        buildTables();
        bus.io_key = '0; bus.io_startKeyExp = 1'b0;
        bus.io_encIntf_text_valid = 1'b0; bus.io_encIntf_text_bits_0 = '0;
        bus.io_decIntf_cipher_valid = 1'b0; bus.io_decIntf_cipher_bits_0 = '0;
        reset = 1'b0;
        tick(2);
        checkAllZero("inReset");
        reset = 1'b1;
        tick(3);
        checkAllZero("afterReset");

        $display("[TB] text request before any key expansion");
        applyStimulus(1, 0, rand128(), '0, 0, 0, encEdge, decEdge, encPulses, decPulses, encOut, decOut, keyDropped);
        checkOutput("earlyText.pulses", 128'(encPulses), 128'd0);

        $display("[TB] FIPS-197 appendix C.1 key");
        loadKey(K1, edges);
        checkOutput("key1.latency", 128'(edges), 128'd10);
        checkOutput("key1.encReady", 128'(bus.io_encEngReady), 128'd1);
        applyStimulus(1, 0, PT1, '0, 0, 0, encEdge, decEdge, encPulses, decPulses, encOut, decOut, keyDropped);
        checkOutput("enc1.edge", 128'(encEdge), 128'd10);
        checkOutput("enc1.pulses", 128'(encPulses), 128'd1);
        checkOutput("enc1.cipher", encOut, CT1);
        checkOutput("enc1.model", encOut, modelEncrypt(K1, PT1));
        checkOutput("enc1.hold", bus.io_encIntf_cipher_bits_0, CT1);
        applyStimulus(0, 1, '0, CT1, 0, 0, encEdge, decEdge, encPulses, decPulses, encOut, decOut, keyDropped);
        checkOutput("dec1.edge", 128'(decEdge), 128'd10);
        checkOutput("dec1.pulses", 128'(decPulses), 128'd1);
        checkOutput("dec1.text", decOut, PT1);

        $display("[TB] key start pulse while encrypt is busy");
        bus.io_key = K2;
        pt = rand128();
        applyStimulus(1, 0, pt, '0, 3, 0, encEdge, decEdge, encPulses, decPulses, encOut, decOut, keyDropped);
        checkOutput("busyStart.keyHeld", 128'(keyDropped), 128'd0);
        checkOutput("busyStart.cipher", encOut, modelEncrypt(K1, pt));
        applyStimulus(1, 0, PT1, '0, 0, 0, encEdge, decEdge, encPulses, decPulses, encOut, decOut, keyDropped);
        checkOutput("busyStart.keysKept", encOut, CT1);

        $display("[TB] FIPS-197 appendix B key, concurrent encrypt and decrypt");
        loadKey(K2, edges);
        checkOutput("key2.latency", 128'(edges), 128'd10);
        applyStimulus(1, 1, PT2, CT2, 0, 0, encEdge, decEdge, encPulses, decPulses, encOut, decOut, keyDropped);
        checkOutput("concur.cipher", encOut, CT2);
        checkOutput("concur.text", decOut, PT2);
        checkOutput("concur.encEdge", 128'(encEdge), 128'd10);
        checkOutput("concur.decEdge", 128'(decEdge), 128'd10);

        $display("[TB] random keys and blocks");
        for (int it = 0; it < 4; it++) begin
            key = rand128(); pt = rand128(); ct = rand128();
            loadKey(key, edges);
            checkOutput($sformatf("rnd%0d.latency", it), 128'(edges), 128'd10);
            applyStimulus(1, 1, pt, ct, 0, 0, encEdge, decEdge, encPulses, decPulses, encOut, decOut, keyDropped);
            checkOutput($sformatf("rnd%0d.cipher", it), encOut, modelEncrypt(key, pt));
            checkOutput($sformatf("rnd%0d.text", it), decOut, modelDecrypt(key, ct));
            checkOutput($sformatf("rnd%0d.decPulses", it), 128'(decPulses), 128'd1);
        end

        $display("[TB] text valid held high runs back to back");
        pt = rand128();
        bus.io_encIntf_text_valid = 1'b1;
        bus.io_encIntf_text_bits_0 = pt;
        first = -1; second = -1;
        for (int n = 0; n < 24; n++) begin
            tick();
            if (bus.io_encIntf_cipher_valid) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
        end
        bus.io_encIntf_text_valid = 1'b0;
        tick(12);
        checkOutput("b2b.first", 128'(first), 128'd10);
        checkOutput("b2b.second", 128'(second), 128'd21);
        checkOutput("b2b.cipher", bus.io_encIntf_cipher_bits_0, modelEncrypt(key, pt));

        $display("[TB] reset in the middle of an encryption");
        applyStimulus(1, 0, rand128(), '0, 0, 4, encEdge, decEdge, encPulses, decPulses, encOut, decOut, keyDropped);
        checkOutput("midReset.pulses", 128'(encPulses), 128'd0);
        checkAllZero("midReset");
        applyStimulus(1, 0, rand128(), '0, 0, 0, encEdge, decEdge, encPulses, decPulses, encOut, decOut, keyDropped);
        checkOutput("midReset.noKeyPulses", 128'(encPulses), 128'd0);
        loadKey(K2, edges);
        applyStimulus(1, 0, PT2, '0, 0, 0, encEdge, decEdge, encPulses, decPulses, encOut, decOut, keyDropped);
        checkOutput("recover.cipher", encOut, CT2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
